imhotep_mem_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch (IF, read-only) and the load/store unit (LSU, read/write).
- Request/grant/rvalid handshake on every side.
- One outstanding transaction at a time.
- Sits between the fetch stage, the LSU and the memory/bus adapter.
- Fixed LSU priority by default; round-robin when the optional feature is compiled in.

---
 rtl/imhotep_pkg.sv | 29 ++
 rtl/imhotep_arb_chk.sv | 24 ++
 rtl/imhotep_arb_pick.sv | 35 +++
 rtl/imhotep_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_imhotep_mem_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/imhotep_pkg.sv
// Shared types and constants for the Imhotep core memory arbiter.
// Round-robin arbitration is selected by defining IMHOTEP_ARB_RR_EN.
package imhotep_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MEM_BE_WIDTH = XLEN / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_SRC_IF  = 1'b0,
    ARB_SRC_LSU = 1'b1
  } arb_src_e;

  function automatic arb_src_e arb_other(input arb_src_e src);
    arb_src_e res;
    if (src == ARB_SRC_IF) begin
      res = ARB_SRC_LSU;
    end else begin
      res = ARB_SRC_IF;
    end
    return res;
  endfunction

endpackage

// File: rtl/imhotep_arb_chk.sv
// Protocol checker for the memory arbiter handshakes.
module imhotep_arb_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic mem_req_i,
  input logic mem_gnt_i,
  input logic mem_rvalid_i,
  input logic if_gnt_i,
  input logic lsu_gnt_i,
  input logic if_rvalid_i,
  input logic lsu_rvalid_i
);

  // Memory must respond at least one cycle after accepting the request.
  a_no_rvalid_with_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_req_i && mem_gnt_i && mem_rvalid_i));

  a_single_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(if_gnt_i && lsu_gnt_i));

  a_single_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(if_rvalid_i && lsu_rvalid_i));

endmodule

// File: rtl/imhotep_arb_pick.sv
// Combinational winner select between fetch and LSU requests.
// IMHOTEP_ARB_RR_EN switches contention from fixed LSU priority to round-robin.
module imhotep_arb_pick
  import imhotep_pkg::*;
(
  input  logic     if_req_i,
  input  logic     lsu_req_i,
  input  arb_src_e last_grant_i,
  output arb_src_e winner_o,
  output logic     valid_o
);

`ifdef IMHOTEP_ARB_RR_EN
  arb_src_e contend_winner_s;
  assign contend_winner_s = arb_other(last_grant_i);
`else
  arb_src_e contend_winner_s;
  logic     unused_last_grant_s;
  assign contend_winner_s    = ARB_SRC_LSU;
  assign unused_last_grant_s = last_grant_i;
`endif

  // Winner selection; only the contended case depends on the policy.
  always_comb begin
    valid_o  = if_req_i | lsu_req_i;
    winner_o = ARB_SRC_IF;
    case ({lsu_req_i, if_req_i})
      2'b01:   winner_o = ARB_SRC_IF;
      2'b10:   winner_o = ARB_SRC_LSU;
      2'b11:   winner_o = contend_winner_s;
      default: winner_o = ARB_SRC_IF;
    endcase
  end

endmodule

// File: rtl/imhotep_mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction in flight.
// Define IMHOTEP_ARB_RR_EN for round-robin arbitration instead of fixed LSU priority.
module imhotep_mem_arbiter #(
  parameter int unsigned XLEN     = imhotep_pkg::XLEN,
  parameter int unsigned BE_WIDTH = XLEN / 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                if_req_i,
  input  logic [XLEN-1:0]     if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [XLEN-1:0]     if_rdata_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [BE_WIDTH-1:0] lsu_be_i,
  input  logic [XLEN-1:0]     lsu_addr_i,
  input  logic [XLEN-1:0]     lsu_wdata_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [XLEN-1:0]     lsu_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [BE_WIDTH-1:0] mem_be_o,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  output logic                busy_o
);
  import imhotep_pkg::*;

  arb_state_e          state_q, state_d;
  arb_src_e            owner_q, owner_d;
  logic                cmd_we_q, cmd_we_d;
  logic [BE_WIDTH-1:0] cmd_be_q, cmd_be_d;
  logic [XLEN-1:0]     cmd_addr_q, cmd_addr_d;
  logic [XLEN-1:0]     cmd_wdata_q, cmd_wdata_d;

  arb_src_e last_grant_s;
  arb_src_e pick_winner_s;
  logic     pick_valid_s;
  logic     load_s;
  logic     gnt_s;
  logic     rsp_s;

  imhotep_arb_pick u_pick (
    .if_req_i     (if_req_i),
    .lsu_req_i    (lsu_req_i),
    .last_grant_i (last_grant_s),
    .winner_o     (pick_winner_s),
    .valid_o      (pick_valid_s)
  );

  assign gnt_s = (state_q == ARB_REQ) & mem_gnt_i;
  assign rsp_s = (state_q == ARB_WAIT) & mem_rvalid_i;

`ifdef IMHOTEP_ARB_RR_EN
  arb_src_e last_grant_q, last_grant_d;

  // Remember who was granted last so contention alternates.
  always_comb begin
    if (gnt_s) begin
      last_grant_d = owner_q;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= ARB_SRC_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_s = last_grant_q;
`else
  assign last_grant_s = ARB_SRC_IF;
`endif

  // Next state; arbitration happens in IDLE or on the response cycle in WAIT.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          state_d = ARB_REQ;
          load_s  = 1'b1;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        if (mem_gnt_i) begin
          state_d = ARB_WAIT;
        end else begin
          state_d = ARB_REQ;
        end
      end
      ARB_WAIT: begin
        if (mem_rvalid_i && pick_valid_s) begin
          state_d = ARB_REQ;
          load_s  = 1'b1;
        end else if (mem_rvalid_i) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Command capture for the winner; fetches are always full-word reads.
  always_comb begin
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_be_d    = cmd_be_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if (load_s) begin
      owner_d = pick_winner_s;
      if (pick_winner_s == ARB_SRC_LSU) begin
        cmd_we_d    = lsu_we_i;
        cmd_be_d    = lsu_be_i;
        cmd_addr_d  = lsu_addr_i;
        cmd_wdata_d = lsu_wdata_i;
      end else begin
        cmd_we_d    = 1'b0;
        cmd_be_d    = {BE_WIDTH{1'b1}};
        cmd_addr_d  = if_addr_i;
        cmd_wdata_d = {XLEN{1'b0}};
      end
    end else begin
      owner_d = owner_q;
    end
  end

  // State, owner and command registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_SRC_IF;
      cmd_we_q    <= 1'b0;
      cmd_be_q    <= {BE_WIDTH{1'b0}};
      cmd_addr_q  <= {XLEN{1'b0}};
      cmd_wdata_q <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_be_q    <= cmd_be_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  assign mem_req_o   = (state_q == ARB_REQ);
  assign mem_we_o    = cmd_we_q;
  assign mem_be_o    = cmd_be_q;
  assign mem_addr_o  = cmd_addr_q;
  assign mem_wdata_o = cmd_wdata_q;
  assign busy_o      = (state_q != ARB_IDLE);

  // Grant and response go only to the registered owner.
  assign if_gnt_o     = gnt_s & (owner_q == ARB_SRC_IF);
  assign lsu_gnt_o    = gnt_s & (owner_q == ARB_SRC_LSU);
  assign if_rvalid_o  = rsp_s & (owner_q == ARB_SRC_IF);
  assign lsu_rvalid_o = rsp_s & (owner_q == ARB_SRC_LSU);
  assign if_rdata_o   = mem_rdata_i;
  assign lsu_rdata_o  = mem_rdata_i;

  imhotep_arb_chk u_chk (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .mem_req_i    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .if_gnt_i     (if_gnt_o),
    .lsu_gnt_i    (lsu_gnt_o),
    .if_rvalid_i  (if_rvalid_o),
    .lsu_rvalid_i (lsu_rvalid_o)
  );

endmodule

// File: tb/tb_imhotep_mem_arbiter.sv
// Directed scoreboard bench for imhotep_mem_arbiter (expects IMHOTEP_ARB_RR_EN consistent with the RTL build).
module tb_imhotep_mem_arbiter;

  logic        clk;
  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  typedef struct {
    logic        src;  // 0 = IF, 1 = LSU
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic lg_model = 1'b0;

  imhotep_mem_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_be_i     (lsu_be_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner on contention according to the bench's policy model.
  function automatic logic model_contend();
`ifdef IMHOTEP_ARB_RR_EN
    return ~lg_model;
`else
    return 1'b1;
`endif
  endfunction

  task automatic push_src(input logic src);
    exp_t e;
    e.src = src;
    if (src) begin
      e.we = lsu_we_i; e.be = lsu_be_i; e.addr = lsu_addr_i; e.wdata = lsu_wdata_i;
    end else begin
      e.we = 1'b0; e.be = 4'hF; e.addr = if_addr_i; e.wdata = 32'h0;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_if(input logic [31:0] addr);
    if_req_i  = 1'b1;
    if_addr_i = addr;
  endtask

  task automatic drive_lsu(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_be_i = be; lsu_addr_i = addr; lsu_wdata_i = wdata;
  endtask

  // Acts as the memory for one transaction; called at posedge+1.
  task automatic serve(input int gnt_wait, input logic [31:0] rdata, input bit expect_now);
    exp_t e;
    int   n;
    e = exp_q.pop_front();
    #2;
    if (expect_now) chk("issue_from_wait", mem_req_o, 32'd1);
    n = 0;
    while (mem_req_o !== 1'b1 && n < 8) begin
      step(); #2; n++;
    end
    chk("mem_req", mem_req_o, 32'd1);
    for (int i = 0; i <= gnt_wait; i++) begin
      if (i > 0) begin step(); #2; end
      chk("mem_addr", mem_addr_o, e.addr);
      chk("mem_we", mem_we_o, e.we);
      chk("mem_be", mem_be_o, e.be);
      chk("mem_wdata", mem_wdata_o, e.wdata);
      chk("busy_req", busy_o, 32'd1);
      if (i < gnt_wait) chk("early_gnt", if_gnt_o | lsu_gnt_o, 32'd0);
    end
    mem_gnt_i = 1'b1;
    #1;
    chk("if_gnt", if_gnt_o, e.src == 1'b0);
    chk("lsu_gnt", lsu_gnt_o, e.src == 1'b1);
    lg_model = e.src;
    step();
    mem_gnt_i = 1'b0;
    if (e.src) lsu_req_i = 1'b0; else if_req_i = 1'b0;
    #1;
    chk("wait_no_req", mem_req_o, 32'd0);
    chk("wait_no_rvalid", if_rvalid_o | lsu_rvalid_o, 32'd0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    #1;
    chk("if_rvalid", if_rvalid_o, e.src == 1'b0);
    chk("lsu_rvalid", lsu_rvalid_o, e.src == 1'b1);
    chk("rdata", e.src ? lsu_rdata_o : if_rdata_o, rdata);
    step();
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    logic w;
    rst_ni = 1'b0; if_req_i = 1'b0; if_addr_i = 32'h0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = 4'h0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hA5A5_5A5A;
    #2;
    chk("rst_mem_req", mem_req_o, 32'd0);
    chk("rst_gnt", if_gnt_o | lsu_gnt_o, 32'd0);
    chk("rst_rvalid", if_rvalid_o | lsu_rvalid_o, 32'd0);
    chk("rst_busy", busy_o, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_if_rdata", if_rdata_o, 32'hA5A5_5A5A);
    chk("rst_lsu_rdata", lsu_rdata_o, 32'hA5A5_5A5A);
    step(); step();
    rst_ni = 1'b1;

    // Fetch only
    drive_if(32'h0000_0100); push_src(1'b0);
    serve(1, 32'h0000_0013, 1'b0);
    #1 chk("idle_after_fetch", busy_o, 32'd0);
    step();

    // Two contention rounds
    for (int r = 0; r < 2; r++) begin
      drive_if(32'h0000_0200 + 32'(r * 4));
      drive_lsu(1'b0, 4'hF, 32'h8000_0000 + 32'(r * 4), 32'h0);
      w = model_contend();
      push_src(w); push_src(~w);
      serve(0, 32'h1111_0000 + 32'(r), 1'b0);
      serve(0, 32'h2222_0000 + 32'(r), 1'b1);
      step();
    end

    // Store with a slow grant
    drive_lsu(1'b1, 4'h3, 32'h0000_0010, 32'hDEAD_BEEF); push_src(1'b1);
    serve(3, 32'h0000_0000, 1'b0);
    step();

    // Reset while waiting for the response
    drive_if(32'h0000_0300);
    step(); #2;
    chk("rw_mem_req", mem_req_o, 32'd1);
    mem_gnt_i = 1'b1; #1;
    chk("rw_if_gnt", if_gnt_o, 32'd1);
    step();
    mem_gnt_i = 1'b0; if_req_i = 1'b0; #1;
    chk("rw_busy_wait", busy_o, 32'd1);
    rst_ni = 1'b0; #1;
    chk("rw_busy_rst", busy_o, 32'd0);
    chk("rw_req_rst", mem_req_o, 32'd0);
    step();
    rst_ni = 1'b1; lg_model = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BAD_0BAD; #1;
    chk("rw_no_rvalid", if_rvalid_o | lsu_rvalid_o, 32'd0);
    chk("rw_busy_after", busy_o, 32'd0);
    step();
    mem_rvalid_i = 1'b0;
    drive_if(32'h0000_0400); push_src(1'b0);
    serve(0, 32'h0000_0093, 1'b0);
    step();

    // Stray response while idle
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777; #1;
    chk("stray_rvalid", if_rvalid_o | lsu_rvalid_o, 32'd0);
    chk("stray_busy", busy_o, 32'd0);
    step();
    mem_rvalid_i = 1'b0; #1;
    chk("stray_busy_after", busy_o, 32'd0);
    chk("stray_mem_req", mem_req_o, 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
